// File: rtl/quad_decoder_if.sv
// quad_decoder_if: encoder pins, control strobes and decoded outputs of quad_decoder
interface quad_decoder_if #(
  parameter int WIDTH  = 12,
  parameter int VWIDTH = 16
);
  logic                     quad_a;
  logic                     quad_b;
  logic                     quad_idx;
  logic [1:0]               mode;
  logic                     idx_en;
  logic                     pos_load;
  logic [WIDTH-1:0]         pos_load_val;
  logic                     err_clr;
  logic [WIDTH-1:0]         pos;
  logic                     dir;
  logic                     step;
  logic                     err;
  logic signed [VWIDTH-1:0] vel;
  logic                     vel_valid;
  modport master (
    output quad_a, quad_b, quad_idx, mode, idx_en, pos_load, pos_load_val, err_clr,
    input  pos, dir, step, err, vel, vel_valid
  );
  modport slave (
    input  quad_a, quad_b, quad_idx, mode, idx_en, pos_load, pos_load_val, err_clr,
    output pos, dir, step, err, vel, vel_valid
  );
endinterface

// File: rtl/quad_decoder.sv
// quad_decoder: filtered quadrature decoder with position, illegal-edge flag and windowed velocity
module quad_decoder #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter bit SATURATE    = 1'b1,
  parameter int VEL_WINDOW  = 50000,
  parameter int VWIDTH      = 16
) (
  input logic clk,
  input logic reset,
  quad_decoder_if.slave bus
);
  localparam int CW = FILTER_LEN < 1 ? 1 : $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(VEL_WINDOW);
  localparam logic [WIDTH-1:0]  PMAX = '1;
  localparam logic [VWIDTH-1:0] VMAX = {1'b0, {(VWIDTH-1){1'b1}}};
  localparam logic [VWIDTH-1:0] VMIN = {1'b1, {(VWIDTH-1){1'b0}}};

  logic [2:0]        sync_q [SYNC_STAGES];
  logic [2:0]        sync_d [SYNC_STAGES];
  logic [2:0]        sync_now;
  logic [2:0]        filt_q, filt_d;
  logic [CW-1:0]     fcnt_q [3];
  logic [CW-1:0]     fcnt_d [3];
  logic [WIDTH-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d, step_q, step_d, err_q, err_d, vv_q, vv_d;
  logic [VWIDTH-1:0] acc_q, acc_d, vel_q, vel_d, acc_nx;
  logic [WW-1:0]     win_q, win_d;
  logic              a_chg, b_chg, count, up, idx_rise, last;

  assign sync_now = sync_q[SYNC_STAGES-1];

  // Synchroniser shift and per-input persistence filter; bit 2 = A, 1 = B, 0 = idx
  always_comb begin
    sync_d[0] = {bus.quad_a, bus.quad_b, bus.quad_idx};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    filt_d = filt_q;
    for (int i = 0; i < 3; i++) begin
      fcnt_d[i] = '0;
      if (sync_now[i] != filt_q[i]) begin
        if (int'(fcnt_q[i]) >= FILTER_LEN) filt_d[i] = sync_now[i];
        else fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  // Decode the committed edge and update position, flags and velocity accumulator
  always_comb begin
    a_chg    = filt_d[2] ^ filt_q[2];
    b_chg    = filt_d[1] ^ filt_q[1];
    up       = filt_q[2] ^ filt_d[1];
    idx_rise = filt_d[0] & ~filt_q[0];
    count    = (a_chg ^ b_chg) & (bus.mode == 2'b01 ? a_chg :
                                  bus.mode == 2'b10 ? a_chg & filt_d[2] : 1'b1);
    pos_d    = bus.pos_load ? bus.pos_load_val :
               bus.idx_en & idx_rise ? '0 :
               !count ? pos_q :
               up ? (SATURATE && pos_q == PMAX ? pos_q : pos_q + 1'b1) :
                    (SATURATE && pos_q == '0 ? pos_q : pos_q - 1'b1);
    dir_d    = count ? up : dir_q;
    step_d   = count;
    err_d    = (a_chg & b_chg) | (err_q & ~bus.err_clr);
    acc_nx   = !count ? acc_q :
               up ? (acc_q == VMAX ? acc_q : acc_q + 1'b1) :
                    (acc_q == VMIN ? acc_q : acc_q - 1'b1);
    last     = win_q == WW'(VEL_WINDOW - 1);
    win_d    = last ? '0 : win_q + 1'b1;
    vel_d    = last ? acc_nx : vel_q;
    acc_d    = last ? '0 : acc_nx;
    vv_d     = last;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      for (int i = 0; i < 3; i++) fcnt_q[i] <= '0;
      filt_q <= '0;
      pos_q  <= '0;
      dir_q  <= 1'b0;
      step_q <= 1'b0;
      err_q  <= 1'b0;
      acc_q  <= '0;
      vel_q  <= '0;
      vv_q   <= 1'b0;
      win_q  <= '0;
    end else begin
      sync_q <= sync_d;
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      err_q  <= err_d;
      acc_q  <= acc_d;
      vel_q  <= vel_d;
      vv_q   <= vv_d;
      win_q  <= win_d;
    end
  end

  assign bus.pos       = pos_q;
  assign bus.dir       = dir_q;
  assign bus.step      = step_q;
  assign bus.err       = err_q;
  assign bus.vel       = vel_q;
  assign bus.vel_valid = vv_q;
endmodule
